// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants, op indices and loader state enum
package isa_pkg;
  localparam int OPC_W   = 27;
  localparam int NUM_OPS = 23;

  localparam logic [4:0] END_IDX = 5'h1F;

  localparam logic [4:0] OP_IDX_NOOP = 5'd0;
  localparam logic [4:0] OP_IDX_ADD  = 5'd7;
  localparam logic [4:0] OP_IDX_ADDI = 5'd8;
  localparam logic [4:0] OP_IDX_BRGE = 5'd22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WR,
    ST_CSUM,
    ST_DONE
  } loader_state_t;
endpackage

// File: rtl/op_onehot_enc.sv
// rtl/op_onehot_enc.sv - 5-bit op index to 23-bit one-hot op field with legality flag
module op_onehot_enc
  import isa_pkg::*;
(
  input  logic [4:0]         idx,
  output logic [NUM_OPS-1:0] onehot,
  output logic               legal
);

  // Index 0 is NOOP (all-zero op field); index k sets bit k-1.
  always_comb begin
    onehot = '0;
    legal  = (idx <= 5'(NUM_OPS));
    for (int k = 1; k <= NUM_OPS; k++) begin
      if (idx == 5'(k)) onehot[k-1] = 1'b1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader into instruction memory
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module instr_loader
  import isa_pkg::*;
#(
  parameter int IMEM_AW = 8,
  parameter int IMM_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     imem_we,
  output logic [IMEM_AW-1:0]       imem_addr,
  output logic [OPC_W+IMM_W-1:0]   imem_wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic [IMEM_AW:0]         count,
  output logic                     err_bad_op,
  output logic                     err_full,
  output logic                     err_csum
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t END_NEXT = ST_CSUM;
`else
  localparam loader_state_t END_NEXT = ST_DONE;
`endif

  loader_state_t      state;
  logic [NUM_OPS-1:0] op_q;
  logic [1:0]         x_q;
  logic [1:0]         y_q;
  logic               frame_bad;
  logic               full;
  logic [NUM_OPS-1:0] enc_onehot;
  logic               enc_legal;
  logic               accept;
  logic               b0_bad;

  op_onehot_enc u_enc (
    .idx    (in_data[4:0]),
    .onehot (enc_onehot),
    .legal  (enc_legal)
  );

  assign in_ready = (state == ST_B0) || (state == ST_B1) ||
                    (state == ST_B2) || (state == ST_CSUM);
  assign cpu_hold = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign accept   = in_valid && in_ready;
  assign b0_bad   = (in_data[7:5] != 3'b000) || !enc_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      count      <= '0;
      err_bad_op <= 1'b0;
      err_full   <= 1'b0;
      full       <= 1'b0;
      op_q       <= '0;
      x_q        <= 2'b00;
      y_q        <= 2'b00;
      frame_bad  <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_B0;
            imem_addr  <= '0;
            count      <= '0;
            full       <= 1'b0;
            err_bad_op <= 1'b0;
            err_full   <= 1'b0;
          end
        end
        ST_B0: begin
          if (accept) begin
            if (in_data == {3'b000, END_IDX}) begin
              state <= END_NEXT;
            end else begin
              op_q      <= enc_onehot;
              frame_bad <= b0_bad;
              if (b0_bad) err_bad_op <= 1'b1;
              state     <= ST_B1;
            end
          end
        end
        ST_B1: begin
          if (accept) begin
            x_q   <= in_data[3:2];
            y_q   <= in_data[1:0];
            state <= ST_B2;
          end
        end
        ST_B2: begin
          if (accept) begin
            imem_wdata <= {x_q, y_q, op_q, in_data[IMM_W-1:0]};
            imem_we    <= !frame_bad && !full;
            if (!frame_bad && full) err_full <= 1'b1;
            state      <= ST_WR;
          end
        end
        ST_WR: begin
          // Saturate at the top address; the full flag blocks further writes.
          if (imem_we) begin
            count <= count + (IMEM_AW+1)'(1);
            if (imem_addr == '1) full <= 1'b1;
            else                 imem_addr <= imem_addr + IMEM_AW'(1);
          end
          state <= ST_B0;
        end
        ST_CSUM: begin
          if (accept) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR covers every accepted byte of the load, END included.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum     <= 8'h00;
      err_csum <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        csum     <= 8'h00;
        err_csum <= 1'b0;
      end
    end else if (accept) begin
      if (state == ST_CSUM) begin
        if (in_data != csum) err_csum <= 1'b1;
      end else begin
        csum <= csum ^ in_data;
      end
    end
  end
`else
  assign err_csum = 1'b0;
`endif

endmodule
